// File: rtl/fifo_sc_stream_out_if.sv
// Valid/ready stream carrying framed words out of the FIFO drain stage.
interface fifo_sc_stream_out_if #(
    parameter int unsigned W = 16
);
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_sc_stream_out.sv
// Drains a one-cycle-latency FIFO read port into a framed valid/ready stream
// through a 3-entry skid buffer, keeping m_ready out of the fifo_read path.
module fifo_sc_stream_out #(
    parameter int unsigned W     = 16,
    parameter int unsigned LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fifo_read,
    input  logic [W-1:0]         fifo_data_out,
    input  logic                 fifo_empty,
    input  logic [LEN_W-1:0]     pkt_len,
    fifo_sc_stream_out_if.master m,
    output logic                 busy
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] cnt;
    logic             infl;
    logic [LEN_W-1:0] wcnt;
    logic [LEN_W-1:0] len_q;

    logic [2:0]       occ;
    logic             accept;
    logic             pop;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] len_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Read issue reserves a slot for the in-flight word, so no overflow is possible
    always_comb begin
        occ       = 3'(cnt) + 3'(infl);
        fifo_read = !rst && !fifo_empty && (occ < 3'(DEPTH));
        accept    = fifo_read && !fifo_empty;
    end

    // Stream outputs and packet framing
    always_comb begin
        m.m_valid = (cnt != '0);
        m.m_data  = mem[rd_ptr];
        pop       = m.m_valid && m.m_ready;
        len_in    = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        len_e     = (wcnt == '0) ? len_in : len_q;
        m.m_last  = m.m_valid && (wcnt == len_e - LEN_W'(1));
        busy      = (cnt != '0) || infl;
    end

    // Buffer storage, pointers and occupancy; an in-flight read is dropped on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            infl   <= 1'b0;
        end else begin
            infl <= accept;
            if (infl) begin
                mem[wr_ptr] <= fifo_data_out;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({infl, pop})
                2'b10:   cnt <= cnt + PTR_W'(1);
                2'b01:   cnt <= cnt - PTR_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Packet length is sampled on the first word of each packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            len_q <= LEN_W'(1);
        end else if (pop) begin
            if (wcnt == '0) begin
                len_q <= len_in;
            end
            wcnt <= m.m_last ? '0 : wcnt + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_sc_stream_out.sv
// Scoreboard bench for fifo_sc_stream_out with a behavioural one-cycle-latency FIFO.
module tb_fifo_sc_stream_out;

    localparam int unsigned W     = 16;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_read;
    logic [W-1:0]     fifo_data_out;
    logic             fifo_empty;
    logic [LEN_W-1:0] pkt_len;
    logic             busy;

    fifo_sc_stream_out_if #(.W(W)) s_if ();

    fifo_sc_stream_out #(.W(W), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .pkt_len       (pkt_len),
        .m             (s_if),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural FIFO: data appears the cycle after an accepted read
    logic [W-1:0] fmem [256];
    int fwr = 0;
    int frd = 0;
    int rd_cnt = 0;
    int rd_cyc [256];
    int cyc = 0;

    assign fifo_empty = (fwr == frd);

    initial begin
        fifo_data_out = '0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (rst) begin
                frd <= fwr;
            end else if (fifo_read && !fifo_empty) begin
                fifo_data_out       <= fmem[frd % 256];
                frd                 <= frd + 1;
                rd_cyc[rd_cnt % 256] <= cyc;
                rd_cnt              <= rd_cnt + 1;
            end
        end
    end

    // Consumer ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
    int rdy_mode = 0;
    initial begin
        s_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       s_if.m_ready = 1'b1;
                1:       s_if.m_ready = ~s_if.m_ready;
                2:       s_if.m_ready = 1'($urandom_range(0, 1));
                default: s_if.m_ready = 1'b0;
            endcase
        end
    end

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cnt = 0;
    int   pop_cyc [256];
    int   drop = 0;

    task automatic push(input logic [W-1:0] d, input logic l);
        exp_t e;
        fmem[fwr % 256] = d;
        fwr++;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented word must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && s_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(s_if.m_data), 32'hFFFF_FFFF);
                end else begin
                    check(s_if.m_ready ? "pop_data" : "stall_data",
                          32'(s_if.m_data), 32'(exp_q[0].d));
                    check(s_if.m_ready ? "pop_last" : "stall_last",
                          32'(s_if.m_last), 32'(exp_q[0].l));
                    if (s_if.m_ready) begin
                        void'(exp_q.pop_front());
                        pop_cyc[pop_cnt % 256] = cyc;
                        pop_cnt++;
                    end
                end
                check("occupancy_le3", 32'((rd_cnt - pop_cnt - drop) <= 3), 32'd1);
            end
        end
    end

    task automatic wait_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(pop_cnt >= target), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int gap_max;

        rst     = 1'b1;
        pkt_len = LEN_W'(1);
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(s_if.m_valid), 32'd0);
        check("rst_last",  32'(s_if.m_last),  32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_data",  32'(s_if.m_data),  32'd0);
        check("rst_read",  32'(fifo_read),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word: 2-cycle read-to-stream latency
        base = pop_cnt;
        push(16'hA5A5, 1'b1);
        #1;
        check("single_read_issued", 32'(fifo_read), 32'd1);
        @(negedge clk);
        check("single_read_once", 32'(fifo_read), 32'd0);
        check("single_valid_t1", 32'(s_if.m_valid), 32'd0);
        check("single_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_valid_t2", 32'(s_if.m_valid), 32'd1);
        wait_pops(base + 1, 20, "single_timeout");
        check("single_idle", 32'(busy), 32'd0);

        // Burst of 16 at full throughput
        pkt_len = LEN_W'(16);
        base  = pop_cnt;
        rbase = rd_cnt;
        for (int i = 0; i < 16; i++) push(W'(i), i == 15);
        wait_pops(base + 16, 100, "burst_timeout");
        check("burst_latency", 32'(pop_cyc[base % 256] - rd_cyc[rbase % 256]), 32'd2);
        gap_max = 0;
        for (int i = 1; i < 16; i++) begin
            if (pop_cyc[(base + i) % 256] - pop_cyc[(base + i - 1) % 256] > gap_max)
                gap_max = pop_cyc[(base + i) % 256] - pop_cyc[(base + i - 1) % 256];
        end
        check("burst_no_gaps", 32'(gap_max), 32'd1);

        // Toggling and random backpressure
        pkt_len  = LEN_W'(4);
        rdy_mode = 1;
        base = pop_cnt;
        for (int i = 0; i < 16; i++) push(W'(16'h0100 + i), (i % 4) == 3);
        wait_pops(base + 16, 200, "toggle_timeout");
        rdy_mode = 2;
        base = pop_cnt;
        for (int i = 0; i < 16; i++) push(W'(16'h0200 + i), (i % 4) == 3);
        wait_pops(base + 16, 400, "random_timeout");

        // Full stall: only three reads may be issued
        rdy_mode = 3;
        repeat (2) @(negedge clk);
        base  = pop_cnt;
        rbase = rd_cnt;
        for (int i = 0; i < 8; i++) push(W'(16'h0300 + i), (i % 4) == 3);
        repeat (10) @(negedge clk);
        check("stall_reads", 32'(rd_cnt - rbase), 32'd3);
        check("stall_read_low", 32'(fifo_read), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        rdy_mode = 0;
        wait_pops(base + 8, 100, "stall_timeout");

        // Framing with a mid-packet length change
        pkt_len = LEN_W'(4);
        base = pop_cnt;
        for (int i = 0; i < 10; i++) push(W'(16'h0400 + i), (i == 3) || (i == 7) || (i == 9));
        for (int n = 0; n < 100 && pop_cnt < base + 6; n++) @(posedge clk);
        #1;
        pkt_len = LEN_W'(2);
        wait_pops(base + 10, 100, "framing_timeout");

        // Zero length behaves as one
        pkt_len = '0;
        base = pop_cnt;
        for (int i = 0; i < 3; i++) push(W'(16'h0500 + i), 1'b1);
        wait_pops(base + 3, 50, "len0_timeout");

        // Reset mid-stream with two buffered words and one in flight
        pkt_len  = LEN_W'(4);
        rdy_mode = 3;
        repeat (2) @(negedge clk);
        push(16'h0600, 1'b0);
        push(16'h0601, 1'b0);
        repeat (4) @(negedge clk);
        push(16'h0602, 1'b0);
        @(posedge clk);
        #1;
        push(16'h0603, 1'b0);
        push(16'h0604, 1'b0);
        check("pre_rst_valid", 32'(s_if.m_valid), 32'd1);
        check("pre_rst_occ", 32'(rd_cnt - pop_cnt - drop), 32'd3);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(s_if.m_valid), 32'd0);
        check("midrst_last",  32'(s_if.m_last),  32'd0);
        check("midrst_busy",  32'(busy),         32'd0);
        check("midrst_read",  32'(fifo_read),    32'd0);
        exp_q.delete();
        drop = rd_cnt - pop_cnt;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rdy_mode = 0;
        base = pop_cnt;
        for (int i = 0; i < 4; i++) push(W'(16'h0700 + i), i == 3);
        wait_pops(base + 4, 50, "post_rst_timeout");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
